// File: rtl/math_issue_queue_if.sv
// rtl/math_issue_queue_if.sv - instruction type and decoder/pipeline-facing bundle for the math issue queue

package math_issue_pkg;

    // One decoded math instruction; valid marks a live request/issue slot.
    typedef struct packed {
        logic        valid;
        logic [1:0]  superscalar_thread;
        logic [3:0]  opcode;
        logic [4:0]  rd;
        logic [31:0] operand_a;
        logic [31:0] operand_b;
    } math_instr;

endpackage

interface math_issue_queue_if #(
    parameter int DEPTH = 4
);
    localparam int OW = $clog2(DEPTH) + 1;

    logic                   freeze;
    math_issue_pkg::math_instr in_instr;
    logic                   in_ready;
    math_issue_pkg::math_instr out_instr;
    logic [OW-1:0]          occupancy;
    logic                   math_busy;

    // Decoder/control side: offers instructions and the global stall.
    modport master (
        output freeze,
        output in_instr,
        input  in_ready,
        input  out_instr,
        input  occupancy,
        input  math_busy
    );

    // Queue side.
    modport slave (
        input  freeze,
        input  in_instr,
        output in_ready,
        output out_instr,
        output occupancy,
        output math_busy
    );
endinterface

// File: rtl/math_issue_queue.sv
// rtl/math_issue_queue.sv - FIFO issue queue feeding math_pipeline with an in-flight writeback shadow

module math_issue_queue #(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    math_issue_queue_if.slave q
);
    localparam int AW = $clog2(DEPTH);
    localparam int OW = AW + 1;

    logic [AW-1:0]             head;
    logic [AW-1:0]             tail;
    logic [OW-1:0]             occ;
    math_issue_pkg::math_instr mem [DEPTH];
    math_issue_pkg::math_instr out_r;
    math_issue_pkg::math_instr head_entry;
    logic [3:0]                sh;
    logic                      full;
    logic                      empty;
    logic                      enq;
    logic                      issue;

    // Handshake qualifiers; in_ready depends only on registered occupancy.
    always_comb begin
        full       = (occ == OW'(DEPTH));
        empty      = (occ == '0);
        enq        = q.in_instr.valid && !full;
        issue      = !q.freeze && !empty;
        head_entry = mem[head];
        head_entry.valid = 1'b1;
    end

    // Entry storage carries no reset; occupancy gating keeps stale slots from issuing.
    always_ff @(posedge clk) begin
        if (enq) begin
            mem[tail] <= q.in_instr;
        end
    end

    // Pointers, occupancy, issue register and in-flight shadow.
    always_ff @(posedge clk) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            occ   <= '0;
            out_r <= '0;
            sh    <= '0;
        end else begin
            if (enq) begin
                tail <= tail + AW'(1);
            end
            if (!q.freeze) begin
                sh <= {sh[2:0], out_r.valid};
                if (!empty) begin
                    out_r <= head_entry;
                    head  <= head + AW'(1);
                end else begin
                    out_r.valid <= 1'b0;
                end
            end
            case ({enq, issue})
                2'b10:   occ <= occ + OW'(1);
                2'b01:   occ <= occ - OW'(1);
                default: occ <= occ;
            endcase
        end
    end

    // Outputs are pure functions of registered state.
    always_comb begin
        q.in_ready  = !full;
        q.out_instr = out_r;
        q.occupancy = occ;
        q.math_busy = !empty || out_r.valid || (|sh);
    end

endmodule

// File: doc/math_issue_queue.md
MATH_ISSUE_QUEUE -- requirements
Module: math_issue_queue

Interface
REQ-001: Module SHALL have one clock and a synchronous, active-high reset: port clk clocks all state, and port reset is sampled only on the rising edge of clk.
REQ-002: Parameter DEPTH, default 4, SHALL set the number of buffered math_instr entries (power of two, 2..16).
REQ-003: clk  input  1  system clock.
REQ-004: reset  input  1  synchronous active-high reset.
REQ-005: freeze  input  1  global stall, shared with math_pipeline.
REQ-006: in_instr  input  math_instr  instruction from decoder; in_instr.valid marks a request.
REQ-007: in_ready  output  1  queue can accept this cycle.
REQ-008: out_instr  output  math_instr  registered instruction driven into math_pipeline instr port.
REQ-009: occupancy  output  $clog2(DEPTH)+1  entries currently buffered.
REQ-010: math_busy  output  1  queue non-empty or any issued instruction not yet written back.

Function
REQ-011: in_ready SHALL equal (occupancy != DEPTH), combinational from registered state only, with no dependence on in_instr or freeze.
REQ-012: Enqueue SHALL occur on an edge where in_instr.valid && in_ready; the full struct is stored; freeze SHALL NOT block enqueue.
REQ-013: in_instr.valid while in_ready=0 SHALL be dropped without any state change; the decoder holds the request.
REQ-014: Issue SHALL occur on an edge where !freeze && occupancy != 0: out_instr <= head entry with valid forced to 1, and the head pointer advances.
REQ-015: On an edge where !freeze && occupancy == 0, out_instr.valid SHALL become 0 and all other out_instr fields SHALL hold.
REQ-016: While freeze=1, out_instr, the head pointer and the in-flight shadow SHALL hold.
REQ-017: Simultaneous enqueue and issue SHALL leave occupancy unchanged; an enqueue into an empty queue SHALL NOT issue in the same edge (minimum latency is 1 edge from accept to out_instr.valid).
REQ-018: Ordering SHALL be strict FIFO across all superscalar_thread values; there is no reordering.
REQ-019: Head and tail pointers SHALL wrap modulo DEPTH; occupancy SHALL never exceed DEPTH or underflow below 0.
REQ-020: In-flight shadow: a 4-bit shift register sh SHALL shift only on !freeze edges, with sh[0] <= out_instr.valid and sh[i] <= sh[i-1]; sh[3] mirrors math_pipeline regfile_we.
REQ-021: math_busy SHALL equal (occupancy != 0) | out_instr.valid | (|sh), combinational from registers.
REQ-022: Throughput SHALL be 1 instruction per unfrozen cycle when the queue is non-empty.

Reset
REQ-023: On a reset edge, occupancy, both pointers, out_instr (entire struct) and sh SHALL clear to 0; in_ready=1 and math_busy=0 on the following cycle.
REQ-024: Reset SHALL take priority over freeze, enqueue and issue on the same edge.
REQ-025: Reset asserted mid-operation SHALL discard all buffered and in-flight instructions; no instruction accepted before reset SHALL issue after reset.
REQ-026: Entry storage SHALL NOT require reset; a stale entry SHALL never issue because occupancy gates issue.

Verification
REQ-027: Single instruction: after reset, push thread 1 at edge 0 with freeze=0 -> out_instr.valid=1 after edge 1, sh[3]=1 after edge 5, math_busy=0 after edge 6.
REQ-028: Fill under freeze: freeze=1, push 5 back-to-back -> first 4 accepted, in_ready=0, occupancy=4, 5th dropped; drop freeze -> 4 issues on 4 consecutive edges in push order.
REQ-029: Streaming: freeze=0, push every cycle for 20 cycles -> occupancy stays at most 1, 20 issues in order, no bubbles after the first.
REQ-030: Freeze mid-flight: issue 2 instructions, then freeze=1 for 3 cycles -> out_instr and sh unchanged during freeze, then resume shifting; math_busy remains 1 throughout.
REQ-031: Wrap-around: 3 rounds of fill-to-DEPTH then drain -> pointer wrap is correct, data matches order, occupancy returns to 0 each round.
REQ-032: Reset mid-operation: occupancy=3 with sh non-zero, assert reset with freeze=1 -> next cycle occupancy=0, out_instr.valid=0, math_busy=0, and nothing issues afterwards.
